// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: the FSM state encoding and a
// compile-time ceil(log2) helper used to size counters.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/full_subtractor_df.sv
// One-bit full subtractor written as pure dataflow: d = x - y - bin,
// with bout asserted when the cell had to borrow from the next bit.
module full_subtractor_df (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit
// per clock through a single full-subtractor cell and a registered borrow.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CNT_W = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    // Bit 0 of a full-width result register would be shifted out before
    // use, so only the upper WIDTH-1 collected bits are stored.
    logic [WIDTH-2:0]   d_sh_q, d_sh_d;
    logic               br_q, br_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cell_d_s;
    logic               cell_bout_s;
    logic [WIDTH-1:0]   d_next_s;

    full_subtractor_df u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (br_q),
        .d    (cell_d_s),
        .bout (cell_bout_s)
    );

    assign d_next_s = {cell_d_s, d_sh_q};

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        d_sh_d     = d_sh_q;
        br_d       = br_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                br_d   = cell_bout_s;
                d_sh_d = d_next_s[WIDTH-1:1];
                if (cnt_q == CNT_LAST) begin
                    state_d    = ST_DONE;
                    diff_d     = d_next_s;
                    borrow_d   = cell_bout_s;
                    // Signed overflow: operands differ in sign and the
                    // result sign differs from the minuend's.
                    overflow_d = (a_msb_q != b_msb_q) && (cell_d_s != a_msb_q);
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            d_sh_q     <= '0;
            br_q       <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            d_sh_q     <= d_sh_d;
            br_q       <= br_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and sweep checks of serial_subtractor (WIDTH=8): results, flags,
// latency, busy span, ignored starts, back-to-back and mid-run reset.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
    logic       overflow;

    int         n_checks;
    int         n_pass;
    logic [7:0] prev_diff;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for done; returns negedges elapsed and busy-high count.
    task automatic wait_done(output int cyc, output int busy_cyc, output bit seen,
                             input bit check_hold);
        cyc = 0;
        busy_cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (busy) busy_cyc = busy_cyc + 1;
            if (check_hold && cyc == 4) check_eq("diff_hold_in_run", 32'(diff), 32'(prev_diff));
            if (done) seen = 1'b1;
        end
    endtask

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ed,
                          input logic eb, input logic eo, input string tag, input bit full);
        int cyc;
        int busy_cyc;
        bit seen;
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ia;
        b = 8'h5A;
        wait_done(cyc, busy_cyc, seen, full);
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (full) begin
            check_eq({tag, "_latency"}, 32'(cyc), 32'd9);
            check_eq({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd9);
        end
        check_eq({tag, "_diff"}, 32'(diff), 32'(ed));
        check_eq({tag, "_borrow"}, 32'(borrow), 32'(eb));
        check_eq({tag, "_overflow"}, 32'(overflow), 32'(eo));
        prev_diff = ed;
        @(negedge clk);
        if (full) begin
            check_eq({tag, "_done_one_cycle"}, 32'(done), 32'd0);
            check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int cyc;
        int busy_cyc;
        int first;
        int second;
        int done_cnt;
        bit seen;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] md;

        n_checks = 0;
        n_pass = 0;
        prev_diff = 8'h00;
        rst_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_diff", 32'(diff), 32'd0);
        check_eq("rst_borrow", 32'(borrow), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        run_op(8'd5,  8'd3,  8'h02, 1'b0, 1'b0, "5m3",   1'b1);
        run_op(8'd3,  8'd5,  8'hFE, 1'b1, 1'b0, "3m5",   1'b1);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "80m01", 1'b1);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "0m0",   1'b1);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "7Fm FF", 1'b1);

        // start pulsed mid-run with different operands must be ignored
        @(negedge clk);
        a = 8'd5;
        b = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'h09;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, busy_cyc, seen, 1'b0);
        check_eq("ign_done_seen", 32'(seen), 32'd1);
        check_eq("ign_diff", 32'(diff), 32'h02);
        check_eq("ign_borrow", 32'(borrow), 32'd0);
        done_cnt = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) done_cnt = done_cnt + 1;
        end
        check_eq("ign_no_queued_done", 32'(done_cnt), 32'd0);

        // back-to-back: start held high continuously
        a = 8'd9;
        b = 8'd4;
        start = 1'b1;
        cyc = 0;
        first = -1;
        second = -1;
        while (second < 0 && cyc < 40) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (done) begin
                if (first < 0) begin
                    first = cyc;
                end else begin
                    second = cyc;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check_eq("b2b_second_seen", 32'(second >= 0), 32'd1);
        check_eq("b2b_spacing", 32'(second - first), 32'd10);
        check_eq("b2b_diff", 32'(diff), 32'h05);
        repeat (3) @(negedge clk);

        // reset mid-operation after a nonzero previous result
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "pre_rst", 1'b0);
        @(negedge clk);
        a = 8'd5;
        b = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_done", 32'(done), 32'd0);
        check_eq("mrst_diff", 32'(diff), 32'd0);
        check_eq("mrst_borrow", 32'(borrow), 32'd0);
        check_eq("mrst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) done_cnt = done_cnt + 1;
        end
        check_eq("mrst_no_done", 32'(done_cnt), 32'd0);
        check_eq("mrst_idle", 32'(busy), 32'd0);
        prev_diff = 8'h00;

        // sweep against a behavioural model
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            md = ra - rb;
            run_op(ra, rb, md, (ra < rb), ((ra[7] != rb[7]) && (md[7] != ra[7])), "rnd", 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
